rock_motor_driver: RTL and testbench

Actuator-side end of the rocking control path. It consumes the `amp`/`freq` setpoints produced by the cradle controller and turns them into a motor drive: a direction signal that swings with a tick-driven phase accumulator, plus a PWM whose duty follows the active amplitude. Setpoint changes are applied only at swing boundaries, and amplitude ramps gradually so the cradle never jerks. It sits between the controller and the motor H-bridge pins.

---
 rtl/rock_pkg.sv | 29 ++
 rtl/rock_pwm.sv | 29 ++
 rtl/rock_motor_driver.sv | 107 ++++++++++
 tb/tb_rock_motor_driver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rock_pkg.sv
// Shared definitions for the rocking control path (controller and motor driver).
package rock_pkg;

    localparam int AMP_W           = 3;
    localparam int FREQ_W          = 3;
    localparam int PHASE_W_DEFAULT = 8;
    localparam int PWM_W_DEFAULT   = 8;

    typedef logic [AMP_W-1:0]  amp_t;
    typedef logic [FREQ_W-1:0] freq_t;

    typedef enum logic {
        MODE_IDLE = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    // Moves the applied amplitude one unit toward the target so the cradle never jerks.
    function automatic amp_t stepToward(input amp_t cur, input amp_t target);
        amp_t result;
        result = cur;
        if (cur < target) begin
            result = cur + amp_t'(1);
        end else if (cur > target) begin
            result = cur - amp_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/rock_pwm.sv
// Free-running PWM counter with a registered compare against the requested duty.
module rock_pwm
    import rock_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty,
    input  logic             en,
    output logic             pwm
);

    logic [PWM_W-1:0] r_cnt;
    logic             r_pwm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_W'(1);
            r_pwm <= en && (r_cnt < duty);
        end
    end

    assign pwm = r_pwm;

endmodule

// File: rtl/rock_motor_driver.sv
// Motor-side driver: tick-driven phase accumulator for direction, ramped amplitude for PWM duty.
module rock_motor_driver
    import rock_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEFAULT,
    parameter int PWM_W   = PWM_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [AMP_W-1:0]  amp,
    input  logic [FREQ_W-1:0] freq,
    output logic              pwm,
    output logic              dir,
    output logic              motor_en,
    output logic [AMP_W-1:0]  act_amp,
    output logic [FREQ_W-1:0] act_freq,
    output logic              cycle_pulse
);

    logic [PHASE_W-1:0] r_phase;
    amp_t               r_actAmp;
    freq_t              r_actFreq;
    logic               r_cyclePulse;

    logic [PHASE_W-1:0] w_phaseNext;
    amp_t               w_actAmpNext;
    freq_t              w_actFreqNext;
    logic               w_cyclePulseNext;
    logic [PHASE_W:0]   w_sum;
    logic               w_wrap;
    logic               w_cross;
    mode_e              w_mode;
    logic [PWM_W-1:0]   w_duty;

    assign w_mode  = (r_actFreq != '0) ? MODE_RUN : MODE_IDLE;
    assign w_sum   = {1'b0, r_phase} + {{(PHASE_W + 1 - FREQ_W){1'b0}}, r_actFreq};
    assign w_wrap  = w_sum[PHASE_W];
    assign w_cross = w_sum[PHASE_W-1] ^ r_phase[PHASE_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= '0;
            r_actAmp     <= '0;
            r_actFreq    <= '0;
            r_cyclePulse <= 1'b0;
        end else begin
            r_phase      <= w_phaseNext;
            r_actAmp     <= w_actAmpNext;
            r_actFreq    <= w_actFreqNext;
            r_cyclePulse <= w_cyclePulseNext;
        end
    end

    // Setpoints are only taken at swing boundaries: freq at start or wrap, amp at half crossings.
    always_comb begin
        w_phaseNext      = r_phase;
        w_actAmpNext     = r_actAmp;
        w_actFreqNext    = r_actFreq;
        w_cyclePulseNext = 1'b0;
        if (tick) begin
            unique case (w_mode)
                MODE_IDLE: begin
                    if (freq != '0) begin
                        w_actFreqNext = freq;
                        w_actAmpNext  = '0;
                    end
                end
                MODE_RUN: begin
                    w_phaseNext = w_sum[PHASE_W-1:0];
                    if (w_cross) begin
                        w_actAmpNext = stepToward(r_actAmp, amp);
                    end
                    if (w_wrap) begin
                        w_cyclePulseNext = 1'b1;
                        if (freq != '0) begin
                            w_actFreqNext = freq;
                        end else begin
                            w_actFreqNext = '0;
                            w_actAmpNext  = '0;
                            w_phaseNext   = '0;
                        end
                    end
                end
            endcase
        end
    end

    assign w_duty = {r_actAmp, {(PWM_W - AMP_W){1'b0}}};

    rock_pwm #(
        .PWM_W(PWM_W)
    ) u_pwm (
        .clk  (clk),
        .reset(reset),
        .duty (w_duty),
        .en   (motor_en),
        .pwm  (pwm)
    );

    assign dir         = r_phase[PHASE_W-1];
    assign motor_en    = (r_actFreq != '0) && (r_actAmp != '0);
    assign act_amp     = r_actAmp;
    assign act_freq    = r_actFreq;
    assign cycle_pulse = r_cyclePulse;

endmodule

// File: tb/tb_rock_motor_driver.sv
// Scoreboard bench for rock_motor_driver: a behavioural swing model predicts every cycle.
module tb_rock_motor_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [2:0] amp;
    logic [2:0] freq;
    logic       pwm;
    logic       dir;
    logic       motor_en;
    logic [2:0] act_amp;
    logic [2:0] act_freq;
    logic       cycle_pulse;

    typedef struct {
        bit dir;
        int actAmp;
        int actFreq;
        bit motorEn;
        bit pulse;
    } expect_t;

    expect_t sbQueue[$];
    int      checkCount = 0;
    int      errorCount = 0;
    int      mPhase = 0;
    int      mAmp = 0;
    int      mFreq = 0;
    bit      mCrossed = 0;

    rock_motor_driver #(
        .PHASE_W(8),
        .PWM_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .amp        (amp),
        .freq       (freq),
        .pwm        (pwm),
        .dir        (dir),
        .motor_en   (motor_en),
        .act_amp    (act_amp),
        .act_freq   (act_freq),
        .cycle_pulse(cycle_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One tick of the reference model working on plain integers over a 256-unit swing.
    task automatic modelTick(output bit pulse);
        int newPhase;
        pulse    = 0;
        mCrossed = 0;
        if (mFreq == 0) begin
            if (freq != 0) begin
                mFreq = int'(freq);
                mAmp  = 0;
            end
        end else begin
            newPhase = mPhase + mFreq;
            mCrossed = (mPhase >= 128) != ((newPhase % 256) >= 128);
            if (mCrossed) begin
                if (mAmp < int'(amp)) mAmp++;
                else if (mAmp > int'(amp)) mAmp--;
            end
            if (newPhase >= 256) begin
                pulse = 1;
                if (freq != 0) begin
                    mFreq  = int'(freq);
                    mPhase = newPhase - 256;
                end else begin
                    mFreq  = 0;
                    mAmp   = 0;
                    mPhase = 0;
                end
            end else begin
                mPhase = newPhase;
            end
        end
    endtask

    task automatic applyStimulus(input bit t);
        expect_t e;
        bit      pulse;
        pulse    = 0;
        mCrossed = 0;
        tick     = t;
        if (t) modelTick(pulse);
        e.dir     = (mPhase >= 128);
        e.actAmp  = mAmp;
        e.actFreq = mFreq;
        e.motorEn = (mAmp != 0) && (mFreq != 0);
        e.pulse   = pulse;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        checkOutput("dir", int'(dir), int'(e.dir));
        checkOutput("act_amp", int'(act_amp), e.actAmp);
        checkOutput("act_freq", int'(act_freq), e.actFreq);
        checkOutput("motor_en", int'(motor_en), int'(e.motorEn));
        checkOutput("cycle_pulse", int'(cycle_pulse), int'(e.pulse));
    endtask

    task automatic tickCrossings(input int n, input string tag);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < 2000) begin
            applyStimulus(1);
            if (mCrossed) seen++;
            guard++;
        end
        if (seen < n) checkOutput(tag, seen, n);
    endtask

    task automatic tickToPhase(input int target, input string tag);
        int guard = 0;
        while (mPhase != target && guard < 2000) begin
            applyStimulus(1);
            guard++;
        end
        if (mPhase != target) checkOutput(tag, mPhase, target);
    endtask

    task automatic countTicksToPulse(output int n);
        n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (!cycle_pulse && n < 600);
    endtask

    task automatic measurePwm(output int highs);
        repeat (2) applyStimulus(0);
        highs = 0;
        repeat (256) begin
            applyStimulus(0);
            if (pwm) highs++;
        end
    endtask

    // Sequence follows a cradle session: idle, start and ramp, re-tune, ramp down, stop, reset.
    initial begin
        int n;
        int highs;
        reset = 1'b0;
        tick  = 1'b0;
        amp   = 3'd0;
        freq  = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pwm", int'(pwm), 0);
        checkOutput("rst_dir", int'(dir), 0);
        checkOutput("rst_motor_en", int'(motor_en), 0);
        checkOutput("rst_act_amp", int'(act_amp), 0);
        checkOutput("rst_act_freq", int'(act_freq), 0);
        checkOutput("rst_cycle_pulse", int'(cycle_pulse), 0);
        reset = 1'b1;
        repeat (2) applyStimulus(0);

        amp  = 3'd7;
        freq = 3'd0;
        repeat (3) applyStimulus(1);
        checkOutput("idle_no_start", int'(act_freq), 0);

        freq = 3'd4;
        applyStimulus(1);
        checkOutput("start_freq", int'(act_freq), 4);
        checkOutput("start_amp", int'(act_amp), 0);
        measurePwm(highs);
        checkOutput("pwm_amp0_highs", highs, 0);

        for (int k = 1; k <= 224; k++) begin
            applyStimulus(1);
            if (k == 32) begin
                checkOutput("t32_dir", int'(dir), 1);
                checkOutput("t32_amp", int'(act_amp), 1);
                checkOutput("t32_motor_en", int'(motor_en), 1);
            end
            if (k == 64) begin
                checkOutput("t64_pulse", int'(cycle_pulse), 1);
                checkOutput("t64_amp", int'(act_amp), 2);
            end
            if (k == 96) begin
                measurePwm(highs);
                checkOutput("pwm_amp3_highs", highs, 96);
            end
        end
        checkOutput("t224_amp", int'(act_amp), 7);

        tickToPhase(40, "reach_phase40");
        freq = 3'd2;
        applyStimulus(1);
        checkOutput("mid_freq_held", int'(act_freq), 4);
        countTicksToPulse(n);
        checkOutput("ticks_to_wrap_f4", n, 53);
        checkOutput("freq_after_wrap", int'(act_freq), 2);
        countTicksToPulse(n);
        checkOutput("ticks_cycle_f2", n, 128);

        amp = 3'd6;
        tickCrossings(1, "cross_to6");
        checkOutput("ramp_amp6", int'(act_amp), 6);
        amp = 3'd2;
        for (int i = 1; i <= 4; i++) begin
            tickCrossings(1, "cross_down");
            checkOutput("ramp_down", int'(act_amp), 6 - i);
        end
        tickCrossings(2, "cross_hold");
        checkOutput("ramp_hold2", int'(act_amp), 2);
        amp = 3'd5;
        tickCrossings(3, "cross_up");
        checkOutput("ramp_up5", int'(act_amp), 5);

        freq = 3'd4;
        n = 0;
        while (mFreq != 4 && n < 400) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("refreq4", int'(act_freq), 4);
        tickToPhase(200, "reach_phase200");
        checkOutput("stop_amp_before", int'(act_amp), 5);
        freq = 3'd0;
        countTicksToPulse(n);
        checkOutput("stop_ticks", n, 14);
        checkOutput("stop_act_freq", int'(act_freq), 0);
        checkOutput("stop_act_amp", int'(act_amp), 0);
        checkOutput("stop_motor_en", int'(motor_en), 0);
        checkOutput("stop_dir", int'(dir), 0);
        repeat (3) applyStimulus(0);
        checkOutput("stop_pwm", int'(pwm), 0);

        amp  = 3'd7;
        freq = 3'd4;
        applyStimulus(1);
        repeat (40) applyStimulus(1);
        tick = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rstmid_pwm", int'(pwm), 0);
        checkOutput("rstmid_dir", int'(dir), 0);
        checkOutput("rstmid_motor_en", int'(motor_en), 0);
        checkOutput("rstmid_act_amp", int'(act_amp), 0);
        checkOutput("rstmid_act_freq", int'(act_freq), 0);
        checkOutput("rstmid_cycle_pulse", int'(cycle_pulse), 0);
        mPhase = 0;
        mAmp   = 0;
        mFreq  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) applyStimulus(0);
        freq = 3'd0;
        repeat (2) applyStimulus(1);
        checkOutput("post_rst_idle", int'(act_freq), 0);
        freq = 3'd4;
        applyStimulus(1);
        checkOutput("post_rst_start", int'(act_freq), 4);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
